// File: rtl/axi_pkg.sv
// Shared AXI encodings and the read-responder state type.
// Used by axi_rd_sram_slave and axi_burst_addr_gen.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [0:0] {
        RD_IDLE,
        RD_BURST
    } rd_state_e;

    // Data bus is 32 bits wide, so beats never exceed 4 bytes.
    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        return (size > 3'd2) ? 3'd2 : size;
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI next-beat address for FIXED/INCR/WRAP bursts.
// Reserved burst type and illegal WRAP lengths fall back to INCR.
module axi_burst_addr_gen
    import axi_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic [2:0]  size_i,
    input  logic [1:0]  burst_i,
    input  logic [3:0]  len_i,
    output logic [31:0] next_addr_o
);

    logic [2:0]  size_c;
    logic [31:0] step;
    logic [31:0] incr_addr;
    logic [31:0] wrap_mask;
    logic        wrap_ok;

    always_comb begin
        size_c    = clamp_size(size_i);
        step      = 32'd1 << size_c;
        incr_addr = addr_i + step;
        wrap_ok   = (len_i == 4'd1) || (len_i == 4'd3) || (len_i == 4'd7) || (len_i == 4'd15);
        // Wrap window is (len+1)*step bytes, a power of two when wrap_ok.
        wrap_mask = (({28'd0, len_i} + 32'd1) << size_c) - 32'd1;

        case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_WRAP: begin
                if (wrap_ok) begin
                    next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
                end else begin
                    next_addr_o = incr_addr;
                end
            end
            default:     next_addr_o = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_rd_sram_slave.sv
// AXI3 read responder over a single-port synchronous SRAM, one burst outstanding.
// Optional AXI_RD_DECERR_EN: out-of-region start addresses answer DECERR without SRAM access.
module axi_rd_sram_slave
    import axi_pkg::*;
#(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned MEM_AW = 14,
    parameter int unsigned DATA_W = 32
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [ID_W-1:0]   s_axi_arid,
    input  logic [31:0]       s_axi_araddr,
    input  logic [3:0]        s_axi_arlen,
    input  logic [2:0]        s_axi_arsize,
    input  logic [1:0]        s_axi_arburst,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [ID_W-1:0]   s_axi_rid,
    output logic [DATA_W-1:0] s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    rd_state_e         state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic [4:0]        issued_q, issued_d;
    logic              rvalid_q, rvalid_d;
    logic              rlast_q, rlast_d;
    logic              decerr_q, decerr_d;
    logic [31:0]       next_addr;
    logic              issue;

    axi_burst_addr_gen u_addr_gen (
        .addr_i      (addr_q),
        .size_i      (size_q),
        .burst_i     (burst_q),
        .len_i       (len_q),
        .next_addr_o (next_addr)
    );

    // A beat slot opens when the output register is empty or draining this cycle.
    assign issue = (state_q == RD_BURST) && (issued_q <= {1'b0, len_q}) &&
                   (!rvalid_q || s_axi_rready);

    assign s_axi_arready = (state_q == RD_IDLE) && !areset;
    assign s_axi_rid     = id_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rresp   = decerr_q ? RESP_DECERR : RESP_OKAY;
    // SRAM holds its output while mem_en is low, so stalled beats stay stable.
    assign s_axi_rdata   = decerr_q ? '0 : mem_rdata;
    assign mem_en        = issue && !decerr_q;
    assign mem_addr      = addr_q[MEM_AW+1:2];

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        addr_d   = addr_q;
        len_d    = len_q;
        size_d   = size_q;
        burst_d  = burst_q;
        issued_d = issued_q;
        rvalid_d = rvalid_q;
        rlast_d  = rlast_q;
        decerr_d = decerr_q;

        case (state_q)
            RD_IDLE: begin
                if (s_axi_arvalid && s_axi_arready) begin
                    id_d     = s_axi_arid;
                    addr_d   = s_axi_araddr;
                    len_d    = s_axi_arlen;
                    size_d   = s_axi_arsize;
                    burst_d  = s_axi_arburst;
                    issued_d = 5'd0;
`ifdef AXI_RD_DECERR_EN
                    decerr_d = |s_axi_araddr[31:MEM_AW+2];
`else
                    decerr_d = 1'b0;
`endif
                    state_d  = RD_BURST;
                end
            end
            RD_BURST: begin
                if (issue) begin
                    issued_d = issued_q + 5'd1;
                    addr_d   = next_addr;
                    rvalid_d = 1'b1;
                    rlast_d  = (issued_q == {1'b0, len_q});
                end else if (s_axi_rready) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                end
                if (rvalid_q && s_axi_rready && rlast_q) begin
                    state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= RD_IDLE;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            issued_q <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            decerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            issued_q <= issued_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            decerr_q <= decerr_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_sram_slave.sv
// Bench for axi_rd_sram_slave: directed and random bursts against an address/data model.
module tb_axi_rd_sram_slave;

    localparam int ID_W   = 4;
    localparam int MEM_AW = 14;
    localparam int DATA_W = 32;

    logic              aclk = 1'b0;
    logic              areset;
    logic [ID_W-1:0]   s_axi_arid;
    logic [31:0]       s_axi_araddr;
    logic [3:0]        s_axi_arlen;
    logic [2:0]        s_axi_arsize;
    logic [1:0]        s_axi_arburst;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [ID_W-1:0]   s_axi_rid;
    logic [DATA_W-1:0] s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rlast;
    logic              s_axi_rvalid;
    logic              s_axi_rready;
    logic              mem_en;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    axi_rd_sram_slave #(
        .ID_W   (ID_W),
        .MEM_AW (MEM_AW),
        .DATA_W (DATA_W)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .mem_en        (mem_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata)
    );

    always #5 aclk = ~aclk;

    function automatic logic [31:0] mem_word(input logic [MEM_AW-1:0] a);
        return 32'hC0DE_0000 ^ ({18'd0, a} * 32'h9E37_79B1);
    endfunction

    // SRAM model: registered read, output held while not enabled.
    always @(posedge aclk) begin
        if (mem_en) mem_rdata <= mem_word(mem_addr);
    end

    // Byte address of beat i, straight from the AXI burst rules.
    function automatic logic [31:0] ref_addr(input logic [31:0] start, input logic [2:0] size,
                                             input logic [1:0] bt, input logic [3:0] len,
                                             input int i);
        longint unsigned step, wl, lower, s;
        int unsigned sz;
        sz   = (size > 3'd2) ? 2 : int'(size);
        step = 64'd1 << sz;
        s    = 64'(start);
        if (bt == 2'b00) return start;
        if (bt == 2'b10 && (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)) begin
            wl    = (64'(len) + 64'd1) * step;
            lower = (s / wl) * wl;
            return 32'(lower + ((s - lower) + 64'(i) * step) % wl);
        end
        return 32'(s + 64'(i) * step);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 rready always high, 1 pattern 1,0,0 repeating, 2 random.
    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] bt, input int mode,
                             input int abort_after);
        bit          dec;
        bit          first_seen;
        bit          stall;
        bit          men_seen;
        int          beats;
        int          cyc;
        int          w;
        logic [31:0] ea;
        logic [31:0] ed;
        logic [31:0] sv_data;
        logic        sv_last;
        logic [3:0]  sv_id;
        logic [1:0]  sv_resp;
`ifdef AXI_RD_DECERR_EN
        dec = (addr[31:MEM_AW+2] != '0);
`else
        dec = 1'b0;
`endif
        @(negedge aclk);
        s_axi_arid    = id;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arsize  = size;
        s_axi_arburst = bt;
        s_axi_arvalid = 1'b1;
        #1;
        w = 0;
        while (!s_axi_arready && w < 20) begin
            @(negedge aclk);
            w++;
        end
        chk("ar_ready", 64'(s_axi_arready), 64'd1);
        @(negedge aclk);
        s_axi_arvalid = 1'b0;
        cyc = 1; beats = 0; first_seen = 0; stall = 0; men_seen = 0;
        sv_data = '0; sv_last = 0; sv_id = '0; sv_resp = '0;
        while (beats <= int'(len) && cyc < 300) begin
            case (mode)
                0:       s_axi_rready = 1'b1;
                1:       s_axi_rready = ((cyc % 3) == 1);
                default: s_axi_rready = 1'($urandom % 2);
            endcase
            #1;
            if (mem_en) men_seen = 1;
            if (cyc == 1) begin
                chk("c1_rvalid", 64'(s_axi_rvalid), 64'd0);
                chk("c1_mem_en", 64'(mem_en), 64'(!dec));
            end
            if (s_axi_rvalid) begin
                if (!first_seen) begin
                    chk("latency", 64'(cyc), 64'd2);
                    first_seen = 1;
                end
                if (stall) begin
                    chk("stall_data", 64'(s_axi_rdata), 64'(sv_data));
                    chk("stall_last", 64'(s_axi_rlast), 64'(sv_last));
                    chk("stall_id", 64'(s_axi_rid), 64'(sv_id));
                    chk("stall_resp", 64'(s_axi_rresp), 64'(sv_resp));
                end
                sv_data = s_axi_rdata; sv_last = s_axi_rlast;
                sv_id = s_axi_rid; sv_resp = s_axi_rresp;
                stall = !s_axi_rready;
                if (s_axi_rready) begin
                    ea = ref_addr(addr, size, bt, len, beats);
                    ed = dec ? 32'd0 : mem_word(ea[MEM_AW+1:2]);
                    chk("rdata", 64'(s_axi_rdata), 64'(ed));
                    chk("rlast", 64'(s_axi_rlast), 64'(beats == int'(len)));
                    chk("rid", 64'(s_axi_rid), 64'(id));
                    chk("rresp", 64'(s_axi_rresp), dec ? 64'd3 : 64'd0);
                    beats++;
                end
            end else begin
                stall = 0;
            end
            @(negedge aclk);
            cyc++;
            if (beats == abort_after) return;
        end
        chk("beat_count", 64'(beats), 64'(int'(len) + 1));
        #1;
        chk("idle_arready", 64'(s_axi_arready), 64'd1);
        chk("idle_rvalid", 64'(s_axi_rvalid), 64'd0);
        if (dec) chk("decerr_no_mem_en", 64'(men_seen), 64'd0);
    endtask

    initial begin
        areset        = 1'b1;
        s_axi_arid    = '0;
        s_axi_araddr  = '0;
        s_axi_arlen   = '0;
        s_axi_arsize  = '0;
        s_axi_arburst = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        repeat (3) @(negedge aclk);
        chk("rst_arready", 64'(s_axi_arready), 64'd0);
        chk("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
        chk("rst_rlast", 64'(s_axi_rlast), 64'd0);
        chk("rst_rid", 64'(s_axi_rid), 64'd0);
        chk("rst_rresp", 64'(s_axi_rresp), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        areset = 1'b0;
        #1;
        chk("rel_arready", 64'(s_axi_arready), 64'd1);

        run_burst(4'h5, 32'h0000_0100, 4'd3, 3'd2, 2'b01, 0, -1);
        run_burst(4'h1, 32'h0000_0108, 4'd3, 3'd2, 2'b10, 0, -1);
        run_burst(4'h2, 32'h0000_0020, 4'd2, 3'd2, 2'b00, 0, -1);
        run_burst(4'h7, 32'h0000_0400, 4'd7, 3'd2, 2'b01, 1, -1);

        // Reset mid-burst after two beats have been accepted.
        run_burst(4'h3, 32'h0000_0200, 4'd3, 3'd2, 2'b01, 0, 2);
        areset = 1'b1;
        #1;
        chk("midrst_rvalid", 64'(s_axi_rvalid), 64'd0);
        chk("midrst_rlast", 64'(s_axi_rlast), 64'd0);
        chk("midrst_mem_en", 64'(mem_en), 64'd0);
        chk("midrst_arready", 64'(s_axi_arready), 64'd0);
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        #1;
        chk("midrst_rel_arready", 64'(s_axi_arready), 64'd1);
        run_burst(4'h4, 32'h0000_0300, 4'd3, 3'd2, 2'b01, 0, -1);

        run_burst(4'h2, 32'h8000_0000, 4'd1, 3'd2, 2'b01, 0, -1);

        for (int n = 0; n < 30; n++) begin
            run_burst(4'($urandom), $urandom, 4'($urandom), 3'($urandom), 2'($urandom), 2, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_rd_sram_slave.md
Name: axi_rd_sram_slave

Overview:
- AXI3 read-channel responder (slave end) fronting a single-port synchronous SRAM.
- Serves CPU-initiated read bursts (boot ROM / instruction memory region) behind the SoC interconnect.
- One outstanding burst; FIXED/INCR/WRAP address generation; full rready backpressure.
- Write channels belong to a separate block.

Parameters:
- ID_W, 4, width of arid/rid.
- MEM_AW, 14, SRAM word-address width; region size 4*2^MEM_AW bytes.
- DATA_W, 32, data bus width; fixed at 32.

Ports:
- aclk  in  1  clock, rising edge.
- areset  in  1  asynchronous active-high reset.
- s_axi_arid  in  ID_W  burst ID.
- s_axi_araddr  in  32  burst start byte address.
- s_axi_arlen  in  4  beats minus one.
- s_axi_arsize  in  3  bytes per beat, log2.
- s_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP.
- s_axi_arvalid  in  1  address valid.
- s_axi_arready  out  1  address accepted.
- s_axi_rid  out  ID_W  echoed burst ID.
- s_axi_rdata  out  DATA_W  read data.
- s_axi_rresp  out  2  response code.
- s_axi_rlast  out  1  final beat.
- s_axi_rvalid  out  1  data valid.
- s_axi_rready  in  1  master accepts data.
- mem_en  out  1  SRAM read enable.
- mem_addr  out  MEM_AW  SRAM word address.
- mem_rdata  in  DATA_W  SRAM data, valid the cycle after mem_en; held while mem_en is low.

Behaviour:
- Reset values: arready=0 while areset is high, 1 in the first IDLE cycle after release. rvalid=0, rlast=0, rid=0, rresp=0, mem_en=0, mem_addr=0. State=IDLE.
- States: IDLE, BURST.
  - IDLE: arready=1. On arvalid&&arready, latch id, addr, len, size and burst; clear issue and return counters; go to BURST; arready=0 next cycle.
  - BURST: arready=0. Returns to IDLE on the cycle after the rvalid&&rready&&rlast handshake, so arready is high again the next cycle.
- Issue rule:
  - mem_en=1 when issued<=len and (rvalid==0 or rready==1).
  - mem_addr = cur_addr[MEM_AW+1:2].
  - Each issue advances cur_addr.
- Return: rvalid is set the cycle after mem_en=1 and holds until rready. rdata is driven from mem_rdata. rlast=1 exactly on beat index len.
- Latency: AR handshake at edge 0 → mem_en in cycle 1 → first rvalid in cycle 2. Sustained throughput is 1 beat/cycle while rready=1.
- Backpressure: while rvalid&&!rready, mem_en=0 and rdata/rid/rlast/rresp stay stable.
- Address generation, with step = 1<<arsize:
  - FIXED: address constant.
  - INCR: addr+step, 32-bit wrap-around.
  - WRAP: wrap length = (len+1)*step, boundary aligned; address wraps to the lower boundary.
  - Reserved burst 11: treated as INCR.
- WRAP with len not in {1,3,7,15}: treated as INCR.
- arsize>2: clamped to 2.
- Narrow sizes: the full word is returned; the master selects lanes.
- rresp=OKAY (00) unless the optional feature is enabled.
- Simultaneous: last-beat handshake and a pending arvalid: the new AR is not accepted until the IDLE cycle.
- areset mid-burst: immediately abandons the burst. rvalid, rlast and mem_en drop asynchronously. No further beats are returned.

Optional Feature:
- AXI_RD_DECERR_EN defined: a burst whose start address has any bit above MEM_AW+1 set returns len+1 beats with rresp=DECERR (11) and rdata=0. mem_en stays 0 for that burst. Beat timing is unchanged.
- Undefined: upper bits are ignored, so addresses alias into the SRAM and rresp is always OKAY.

Decomposition:
- Shared package axi_pkg holds:
  - burst codes BURST_FIXED/INCR/WRAP.
  - resp codes RESP_OKAY/EXOKAY/SLVERR/DECERR.
  - state enum RD_IDLE/RD_BURST.
- One sub-module, axi_burst_addr_gen: combinational next-address from addr/size/burst/len. It is reusable by the future write responder.

Test Plan:
- INCR, arlen=3, araddr=0x100, rready=1 → 4 beats from words 0x40..0x43 in consecutive cycles; rlast on beat 3; rid echoes arid=0x5.
- WRAP, arlen=3, araddr=0x108 → word addresses 0x42,0x43,0x40,0x41.
- FIXED, arlen=2, araddr=0x20 → three beats, all word 0x08.
- INCR, arlen=7, rready toggling 1,0,0,1… → no beat lost or duplicated; rdata stable while stalled; exactly 8 handshakes.
- areset pulsed after beat 1 of a 4-beat burst → rvalid=0 immediately; arready=1 the first cycle after release; next burst returns correct data.
- With AXI_RD_DECERR_EN, araddr=0x8000_0000, arlen=1 → 2 beats with rresp=11 and rdata=0; mem_en never asserted.
